// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time and period of an asynchronous PWM input.
// Results are counted in ticks; a stuck flag reports a waveform with no edges.
module pwm_decoder #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         tick,
  input  logic         pwm_in,
  output logic [n-1:0] high_count,
  output logic [n-1:0] period_count,
  output logic         valid,
  output logic         stuck,
  output logic         stuck_level
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    HIGH,
    LOW
  } state_t;

  localparam logic [n-1:0] MAX = '1;
  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_state_nx;

  logic r_sync1;
  logic r_pwm_s;
  logic r_pwm_d;
  logic w_rise;
  logic w_fall;
  logic w_timeout;

  logic [n-1:0] r_cnt_high;
  logic [n-1:0] r_cnt_period;
  logic [n-1:0] w_cnt_high_nx;
  logic [n-1:0] w_cnt_period_nx;
  logic [n-1:0] w_load;
  logic [n-1:0] w_period_inc;

  logic [n-1:0] r_high_count;
  logic [n-1:0] r_period_count;
  logic [n-1:0] w_high_count_nx;
  logic [n-1:0] w_period_count_nx;
  logic         r_valid;
  logic         w_valid_nx;
  logic         r_stuck;
  logic         w_stuck_nx;
  logic         r_stuck_level;
  logic         w_stuck_level_nx;

  assign w_rise       = r_pwm_s & ~r_pwm_d;
  assign w_fall       = ~r_pwm_s & r_pwm_d;
  assign w_timeout    = tick & (r_cnt_period == MAX);
  assign w_load       = {{(n-1){1'b0}}, tick};
  // Saturates so the period counter can never wrap.
  assign w_period_inc = (r_cnt_period == MAX) ? MAX
                                              : r_cnt_period + ONE;

  // Two-flop synchronizer plus delay flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_pwm_s <= 1'b0;
      r_pwm_d <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_pwm_s <= r_sync1;
      r_pwm_d <= r_pwm_s;
    end
  end

  // State, counters and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt_high     <= '0;
      r_cnt_period   <= '0;
      r_high_count   <= '0;
      r_period_count <= '0;
      r_valid        <= 1'b0;
      r_stuck        <= 1'b0;
      r_stuck_level  <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt_high     <= w_cnt_high_nx;
      r_cnt_period   <= w_cnt_period_nx;
      r_high_count   <= w_high_count_nx;
      r_period_count <= w_period_count_nx;
      r_valid        <= w_valid_nx;
      r_stuck        <= w_stuck_nx;
      r_stuck_level  <= w_stuck_level_nx;
    end
  end

  // Next-state, counting, result capture and timeout detection.
  always_comb begin
    w_state_nx        = r_state;
    w_cnt_high_nx     = r_cnt_high;
    w_cnt_period_nx   = r_cnt_period;
    w_high_count_nx   = r_high_count;
    w_period_count_nx = r_period_count;
    w_valid_nx        = 1'b0;
    w_stuck_nx        = r_stuck;
    w_stuck_level_nx  = r_stuck_level;
    if (!enable) begin
      w_state_nx = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nx = SYNC;
        end
        SYNC: begin
          if (w_rise) begin
            w_state_nx      = HIGH;
            w_cnt_high_nx   = w_load;
            w_cnt_period_nx = w_load;
          end
        end
        HIGH: begin
          if (w_fall) begin
            w_state_nx = LOW;
            if (tick) w_cnt_period_nx = w_period_inc;
          end else if (w_timeout) begin
            w_state_nx       = SYNC;
            w_stuck_nx       = 1'b1;
            w_stuck_level_nx = r_pwm_s;
          end else if (tick) begin
            w_cnt_high_nx   = r_cnt_high + ONE;
            w_cnt_period_nx = w_period_inc;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_state_nx        = HIGH;
            w_high_count_nx   = r_cnt_high;
            w_period_count_nx = r_cnt_period;
            w_valid_nx        = 1'b1;
            w_stuck_nx        = 1'b0;
            w_cnt_high_nx     = w_load;
            w_cnt_period_nx   = w_load;
          end else if (w_timeout) begin
            w_state_nx       = SYNC;
            w_stuck_nx       = 1'b1;
            w_stuck_level_nx = r_pwm_s;
          end else if (tick) begin
            w_cnt_period_nx = w_period_inc;
          end
        end
        default: begin
          w_state_nx = IDLE;
        end
      endcase
    end
  end

  assign high_count   = r_high_count;
  assign period_count = r_period_count;
  assign valid        = r_valid;
  assign stuck        = r_stuck;
  assign stuck_level  = r_stuck_level;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: periods, tick division, glitches,
// timeout, enable drop and asynchronous reset.
module tb_pwm_decoder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         tick;
  logic         tick_mode;
  logic         pwm_in = 1'b0;
  logic [N-1:0] high_count;
  logic [N-1:0] period_count;
  logic         valid;
  logic         stuck;
  logic         stuck_level;

  logic [1:0] tdiv = 2'd0;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int t_rise = 0;
  int vcnt = 0;
  int last_lat = -1;
  int stuck_lat = -1;
  int v0 = 0;
  logic pwm_prev = 1'b0;
  logic stuck_prev = 1'b0;

  pwm_decoder #(.n(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tick         (tick),
    .pwm_in       (pwm_in),
    .high_count   (high_count),
    .period_count (period_count),
    .valid        (valid),
    .stuck        (stuck),
    .stuck_level  (stuck_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tdiv <= tdiv + 2'd1;

  assign tick = tick_mode ? (tdiv == 2'd0) : 1'b1;

  // Edge index of the last sample where pwm_in was seen rising.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pwm_prev <= pwm_in;
    if (pwm_in && !pwm_prev) t_rise <= cyc;
  end

  // Valid-cycle count, valid latency and stuck latency from that edge.
  always @(negedge clk) begin
    stuck_prev <= stuck;
    if (valid) begin
      vcnt     <= vcnt + 1;
      last_lat <= cyc - 1 - t_rise;
    end
    if (stuck && !stuck_prev) stuck_lat <= cyc - 1 - t_rise;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic drive(input int hi, input int lo, input int np);
    repeat (np) begin
      pwm_in = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    tick_mode = 1'b0;
    pwm_in    = 1'b0;
    cyc_n(3);
    #1;
    check("rst_high", high_count, 0);
    check("rst_period", period_count, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_level", stuck_level, 0);

    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    cyc_n(3);

    // 3 high / 7 low at clk rate
    v0 = vcnt;
    drive(3, 7, 5);
    #1;
    check("p37_nvalid", vcnt - v0, 4);
    check("p37_high", high_count, 3);
    check("p37_period", period_count, 10);
    check("p37_latency", last_lat, 2);
    check("p37_stuck", stuck, 0);

    // tick every 4th clk, 12 high / 28 low
    tick_mode = 1'b1;
    v0 = vcnt;
    drive(12, 28, 4);
    #1;
    check("div4_nvalid", vcnt - v0, 4);
    check("div4_high", high_count, 3);
    check("div4_period", period_count, 10);

    // one-clk high pulses
    tick_mode = 1'b0;
    drive(1, 9, 3);
    #1;
    check("glitch_high", high_count, 1);
    check("glitch_period", period_count, 10);

    // hold low after valid periods -> timeout
    drive(3, 7, 2);
    pwm_in = 1'b0;
    cyc_n(300);
    #1;
    check("stk0_stuck", stuck, 1);
    check("stk0_latency", stuck_lat, 257);
    check("stk0_level", stuck_level, 0);
    check("stk0_high", high_count, 3);
    check("stk0_period", period_count, 10);

    // hold high -> timeout with level 1
    v0 = vcnt;
    pwm_in = 1'b1;
    cyc_n(300);
    #1;
    check("stk1_stuck", stuck, 1);
    check("stk1_level", stuck_level, 1);
    check("stk1_nvalid", vcnt - v0, 0);

    // recovery after stuck
    pwm_in = 1'b0;
    cyc_n(5);
    v0 = vcnt;
    drive(4, 5, 3);
    #1;
    check("rec_nvalid", vcnt - v0, 2);
    check("rec_stuck", stuck, 0);
    check("rec_high", high_count, 4);
    check("rec_period", period_count, 9);

    // enable dropped during LOW
    pwm_in = 1'b1;
    cyc_n(4);
    pwm_in = 1'b0;
    cyc_n(5);
    #1;
    check("en_pre_high", high_count, 4);
    check("en_pre_period", period_count, 9);
    v0 = vcnt;
    enable = 1'b0;
    cyc_n(3);
    enable = 1'b1;
    cyc_n(3);
    #1;
    check("en_hold_nvalid", vcnt - v0, 0);
    check("en_hold_high", high_count, 4);
    check("en_hold_period", period_count, 9);
    drive(5, 6, 2);
    #1;
    check("en_new_nvalid", vcnt - v0, 1);
    check("en_new_high", high_count, 5);
    check("en_new_period", period_count, 11);

    // asynchronous reset in HIGH
    pwm_in = 1'b1;
    cyc_n(3);
    #3;
    reset = 1'b1;
    #1;
    check("arst_high", high_count, 0);
    check("arst_period", period_count, 0);
    check("arst_valid", valid, 0);
    check("arst_stuck", stuck, 0);
    @(negedge clk);
    reset  = 1'b0;
    pwm_in = 1'b0;
    cyc_n(3);
    v0 = vcnt;
    drive(3, 7, 3);
    #1;
    check("post_nvalid", vcnt - v0, 2);
    check("post_high", high_count, 3);
    check("post_period", period_count, 10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter n, default 8: width of all measurement counters and results.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset of all state.
REQ-004 SHALL have port enable  input  1  measurement enable; low forces IDLE.
REQ-005 SHALL have port tick  input  1  count-enable strobe from a timer_input saturation output, or tied 1'b1 for clk-rate counting.
REQ-006 SHALL have port pwm_in  input  1  asynchronous PWM waveform under measurement.
REQ-007 SHALL have port high_count  output  n  ticks the signal was high in the last complete period.
REQ-008 SHALL have port period_count  output  n  ticks in the last complete period, rise to rise.
REQ-009 SHALL have port valid  output  1  one-clk pulse when high_count/period_count update.
REQ-010 SHALL have port stuck  output  1  no edge within 2^n-1 ticks; waveform constant.
REQ-011 SHALL have port stuck_level  output  1  synchronized pwm_in level when stuck was set.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer (pwm_s), then a delay flop (pwm_d); rise = pwm_s & ~pwm_d, fall = ~pwm_s & pwm_d.
REQ-013 SHALL implement FSM states IDLE, SYNC, HIGH, LOW; every measurement arithmetic and transition uses only synchronized signals.
REQ-014 IDLE: entered whenever enable=0, from any state, on the next edge; leaving IDLE (enable=1) goes to SYNC.
REQ-015 SYNC: waits for rise, no counting; a fall is ignored; on rise -> HIGH.
REQ-016 Two internal counters cnt_high, cnt_period (n bits); on a rise-detect cycle both load (tick ? 1 : 0).
REQ-017 In HIGH, on a non-fall cycle both counters increment when tick=1; on fall -> LOW, cnt_period increments when tick=1, cnt_high holds.
REQ-018 In LOW, on a non-rise cycle cnt_period increments when tick=1; tick=0 holds both counters.
REQ-019 On rise in LOW: high_count <= cnt_high, period_count <= cnt_period, valid=1 for exactly one clk, stuck <= 0, counters reload per REQ-016, stay in HIGH.
REQ-020 The rise that moves SYNC -> HIGH SHALL NOT assert valid (no complete period yet).
REQ-021 Latency: valid rises on the 3rd rising clk edge after the first edge at which pwm_in is sampled high.
REQ-022 Timeout: in HIGH or LOW, if cnt_period = 2^n-1 and tick=1 with no edge detected, the FSM SHALL go to SYNC, set stuck=1, set stuck_level=pwm_s, not assert valid; counters never wrap.
REQ-023 high_count/period_count/stuck_level SHALL hold between updates; only REQ-019 and reset change them.
REQ-024 stuck SHALL clear only on the next valid (REQ-019) or on reset; leaving to IDLE keeps it.
REQ-025 Glitch handling: a pulse shorter than one clk may be missed; a high pulse detected as rise then fall on consecutive cycles SHALL be measured as high_count=1 (tick=1).
REQ-026 high_count <= period_count SHALL hold for every valid result.

Reset
REQ-027 While reset=1: state=IDLE, synchronizer/delay flops=0, counters=0, high_count=0, period_count=0, valid=0, stuck=0, stuck_level=0, regardless of clk.
REQ-028 Reset asserted mid-measurement SHALL discard the partial period; after release the first valid requires one full period after entering SYNC.

Verification
REQ-029 n=8, tick=1, enable=1, pwm_in 3 clk high / 7 clk low repeating -> first valid after the 2nd rise, high_count=3, period_count=10, valid one clk per period thereafter.
REQ-030 n=8, tick every 4th clk, pwm_in 12 clk high / 28 low, aligned -> high_count=3, period_count=10.
REQ-031 n=8, tick=1, pwm_in held 0 after one valid period -> stuck=1, stuck_level=0 exactly 255 ticks after the last rise-detect; pwm_in held 1 -> stuck_level=1; next full period -> valid and stuck=0.
REQ-032 enable dropped during LOW, then restored -> no valid for the broken period; next valid only after SYNC plus one full period; outputs hold old values meanwhile.
REQ-033 reset pulsed mid-HIGH -> all outputs 0 immediately (asynchronous); after release, measurements per REQ-029 resume.
REQ-034 Loopback: pwm_in driven by a pwm_improved instance (n=8, duty=64, shared tick source) -> high_count=64, period_count=256 saturates -> stuck behaviour per REQ-022; with period <256 ticks, high_count equals programmed duty.
